// File: rtl/wishbone_nn_host.sv
// Wishbone classic single-master initiator: turns a valid/ready command stream into
// single writes or incrementing read bursts, and returns each beat on a response stream.
module wishbone_nn_host #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_LEN_W = 4
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_we,
  input  logic [31:0]          cmd_adr,
  input  logic [31:0]          cmd_dat,
  input  logic [3:0]           cmd_sel,
  input  logic [MAX_LEN_W-1:0] cmd_len,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic                 wbm_we_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_adr_o,
  output logic [31:0]          wbm_dat_o,
  input  logic                 wbm_ack_i,
  input  logic [31:0]          wbm_dat_i,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_dat,
  output logic                 rsp_err,
  output logic                 rsp_last
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  state_t               state;
  logic [MAX_LEN_W-1:0] remaining;
  logic [TW-1:0]        tmo_cnt;
  logic                 tmo_hit;

  // Expiry fires on the TIMEOUT-th BUS cycle of a beat, so stb is high exactly TIMEOUT cycles.
  assign tmo_hit = (TIMEOUT != 0) && ((tmo_cnt + 1'b1) == TW'(TIMEOUT));

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state     <= IDLE;
      remaining <= '0;
      tmo_cnt   <= '0;
      cmd_ready <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_dat;
            wbm_sel_o <= cmd_sel;
            remaining <= cmd_we ? '0 : cmd_len;
            tmo_cnt   <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= BUS;
          end
        end
        BUS: begin
          // Ack takes priority over a watchdog expiry in the same cycle.
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= wbm_we_o ? 32'h0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_last  <= (remaining == '0);
            state     <= RSP;
          end else if (tmo_hit) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_dat   <= 32'h0;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
            remaining <= '0;
            state     <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              rsp_dat   <= 32'h0;
              rsp_err   <= 1'b0;
              rsp_last  <= 1'b0;
              cmd_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              wbm_adr_o <= wbm_adr_o + 32'd4;
              remaining <= remaining - 1'b1;
              tmo_cnt   <= '0;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              state     <= BUS;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_nn_host.sv
// Randomized bench for wishbone_nn_host: a behavioural slave with configurable wait states
// and a command-level reference model of the expected bus beats and responses.
module tb_wishbone_nn_host;

  localparam int TMO = 8;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we    = 1'b0;
  logic [31:0] cmd_adr   = '0;
  logic [31:0] cmd_dat   = '0;
  logic [3:0]  cmd_sel   = '0;
  logic [3:0]  cmd_len   = '0;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_last;

  int check_count = 0;
  int fail_count  = 0;

  int slave_wait  = 0;
  bit slave_never = 1'b0;
  int stb_cnt     = 0;

  typedef struct packed {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
  } beat_t;

  beat_t beat_q[$];
  int    run_q[$];
  int    stb_run = 0;

  wishbone_nn_host #(.TIMEOUT(TMO), .MAX_LEN_W(4)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_we   (cmd_we),
    .cmd_adr  (cmd_adr),
    .cmd_dat  (cmd_dat),
    .cmd_sel  (cmd_sel),
    .cmd_len  (cmd_len),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .rsp_last (rsp_last)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Slave acks after slave_wait stall cycles, or never; read data is a function of the address.
  always_comb begin
    wbm_ack_i = wbm_cyc_o && wbm_stb_o && !slave_never && (stb_cnt == slave_wait);
    wbm_dat_i = wbm_ack_i ? (wbm_adr_o ^ 32'hA5A5A5A5) : 32'h0;
  end

  always @(posedge wb_clk_i) begin
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i) stb_cnt <= stb_cnt + 1;
    else stb_cnt <= 0;
  end

  // Bus monitor: records acked beats and the length of every contiguous strobe run.
  always @(negedge wb_clk_i) begin
    beat_t b;
    if (wbm_cyc_o && wbm_stb_o) begin
      stb_run++;
      checkOutput("busy_cmd_ready", {31'h0, cmd_ready}, 32'h0);
      if (wbm_ack_i) begin
        b.adr = wbm_adr_o;
        b.we  = wbm_we_o;
        b.sel = wbm_sel_o;
        b.dat = wbm_dat_o;
        beat_q.push_back(b);
      end
    end else if (stb_run != 0) begin
      run_q.push_back(stb_run);
      stb_run = 0;
    end
  end

  task automatic waitReady();
    bit seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge wb_clk_i);
      if (cmd_ready) seen = 1'b1;
    end
    checkOutput("cmd_ready_wait", {31'h0, seen}, 32'h1);
  endtask

  task automatic applyStimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [3:0] sel, input logic [3:0] len,
                               input int wait_cycles, input bit never, input bit stall);
    int          n_beats;
    int          n_resp;
    logic [31:0] exp_adr[$];
    logic [31:0] exp_dat[$];
    logic        exp_last[$];
    int          got;
    bit          done;
    bit          stalled;
    logic [31:0] snap_dat;
    logic        snap_last;
    logic        snap_err;
    logic [31:0] a;

    // Reference model: beat addresses, response data and last flags for the whole command.
    n_beats = we ? 1 : int'(len) + 1;
    for (int i = 0; i < n_beats; i++) begin
      a = adr + 32'(4 * i);
      exp_adr.push_back(a);
      exp_dat.push_back(we ? 32'h0 : (a ^ 32'hA5A5A5A5));
      exp_last.push_back(i == n_beats - 1);
    end
    n_resp = never ? 1 : n_beats;

    slave_wait  = wait_cycles;
    slave_never = never;
    rsp_ready   = !stall;
    waitReady();
    beat_q.delete();
    run_q.delete();
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_len   = len;
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b0;
    cmd_adr   = $urandom;

    got = 0;
    done = 1'b0;
    stalled = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge wb_clk_i);
      if (rsp_valid) begin
        if (stall && !stalled) begin
          snap_dat  = rsp_dat;
          snap_last = rsp_last;
          snap_err  = rsp_err;
          repeat (5) begin
            @(negedge wb_clk_i);
            checkOutput("stall_valid", {31'h0, rsp_valid}, 32'h1);
            checkOutput("stall_dat", rsp_dat, snap_dat);
            checkOutput("stall_last", {31'h0, rsp_last}, {31'h0, snap_last});
            checkOutput("stall_err", {31'h0, rsp_err}, {31'h0, snap_err});
            checkOutput("stall_stb", {31'h0, wbm_stb_o}, 32'h0);
          end
          rsp_ready = 1'b1;
          stalled = 1'b1;
        end
        if (never) begin
          checkOutput("rsp_dat", rsp_dat, 32'h0);
          checkOutput("rsp_err", {31'h0, rsp_err}, 32'h1);
          checkOutput("rsp_last", {31'h0, rsp_last}, 32'h1);
        end else begin
          checkOutput("rsp_dat", rsp_dat, exp_dat[got]);
          checkOutput("rsp_err", {31'h0, rsp_err}, 32'h0);
          checkOutput("rsp_last", {31'h0, rsp_last}, {31'h0, exp_last[got]});
        end
        got++;
        if (got >= n_resp) done = 1'b1;
      end
    end
    checkOutput("rsp_count", got, n_resp);

    @(negedge wb_clk_i);
    checkOutput("idle_cmd_ready", {31'h0, cmd_ready}, 32'h1);
    checkOutput("idle_rsp_valid", {31'h0, rsp_valid}, 32'h0);

    checkOutput("beat_count", beat_q.size(), never ? 0 : n_beats);
    for (int i = 0; i < beat_q.size() && i < n_beats && !never; i++) begin
      checkOutput("beat_adr", beat_q[i].adr, exp_adr[i]);
      checkOutput("beat_we", {31'h0, beat_q[i].we}, {31'h0, we});
      checkOutput("beat_sel", {28'h0, beat_q[i].sel}, {28'h0, sel});
      checkOutput("beat_dat", beat_q[i].dat, dat);
    end
    checkOutput("run_count", run_q.size(), never ? 1 : n_beats);
    for (int i = 0; i < run_q.size() && i < n_beats; i++)
      checkOutput("stb_cycles", run_q[i], never ? TMO : wait_cycles + 1);
  endtask

  initial begin
    bit seen;

    $display("[TB] start");
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    checkOutput("rst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    checkOutput("rst_stb", {31'h0, wbm_stb_o}, 32'h0);
    checkOutput("rst_cmd_ready", {31'h0, cmd_ready}, 32'h0);
    checkOutput("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    checkOutput("rst_adr", wbm_adr_o, 32'h0);
    wb_rst_ni = 1'b1;

    applyStimulus(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 4'd5, 2, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h3000_0010, 32'h1234_5678, 4'hF, 4'd3, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFC, 32'h0, 4'h3, 4'd1, 0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h2000_0040, 32'h0, 4'hF, 4'd3, 0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h1000_0100, 32'h0, 4'hF, 4'd3, 1, 1'b0, 1'b1);
    applyStimulus(1'b0, 32'h1000_0200, 32'h0, 4'hF, 4'd0, TMO - 1, 1'b0, 1'b0);

    // Reset while the second beat of a burst is on the bus.
    slave_wait  = 2;
    slave_never = 1'b0;
    rsp_ready   = 1'b1;
    waitReady();
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_adr   = 32'h4000_0000;
    cmd_len   = 4'd3;
    @(posedge wb_clk_i);
    #1;
    cmd_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge wb_clk_i);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("rst_first_rsp", {31'h0, seen}, 32'h1);
    @(negedge wb_clk_i);
    checkOutput("rst_beat2_stb", {31'h0, wbm_stb_o}, 32'h1);
    wb_rst_ni = 1'b0;
    @(posedge wb_clk_i);
    #1;
    checkOutput("midrst_cyc", {31'h0, wbm_cyc_o}, 32'h0);
    checkOutput("midrst_stb", {31'h0, wbm_stb_o}, 32'h0);
    checkOutput("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checkOutput("postrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    applyStimulus(1'b0, 32'h5000_0008, 32'h0, 4'hF, 4'd2, 0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), $urandom_range(0, TMO - 1),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/wishbone_nn_host.md
Name: wishbone_nn_host

Overview:
- Wishbone classic single-master initiator that drives transactions into the wishbone_nn slave port, e.g. from a test harness or an on-chip controller.
- Converts a valid/ready command stream into Wishbone cycles and returns read data and status on a valid/ready response stream.
- Supports single writes and incrementing read bursts, with a bus-timeout watchdog.

Parameters:
- TIMEOUT, 255, cycles to wait for wbm_ack_i before aborting a beat. 0 disables the watchdog. Counter width is clog2(TIMEOUT+1).
- MAX_LEN_W, 4, width of cmd_len. A burst is at most 2^MAX_LEN_W beats.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  byte address; word aligned; bits [1:0] are forwarded unchanged.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte enables.
- cmd_len  in  MAX_LEN_W  beats minus 1. Reads only; forced to 0 for writes.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte select.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.
- rsp_valid  out  1  response offered.
- rsp_ready  in  1  response consumed when both rsp_valid and rsp_ready are high.
- rsp_dat  out  32  read data; 0 for writes and for timeouts.
- rsp_err  out  1  beat aborted by timeout.
- rsp_last  out  1  final response of the command.

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge):
  - All wbm_* outputs, rsp_* outputs and cmd_ready go to 0.
  - The timeout counter and beat counter clear.
  - The FSM enters IDLE.
  - Reset mid-transfer drops cyc/stb at that edge and discards the burst; no response is emitted.
- FSM states: IDLE, BUS, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept, latch we, adr, dat, sel and remaining = (we ? 0 : cmd_len), then go to BUS.
- BUS:
  - cyc=stb=1; adr/dat/sel/we come from the latched values and are stable for the whole beat; cmd_ready=0.
  - Timeout counter increments every BUS cycle.
  - On wbm_ack_i: capture wbm_dat_i (writes capture 0), rsp_err=0, deassert cyc/stb at that edge, go to RSP.
  - If the counter reaches TIMEOUT with no ack (TIMEOUT≠0): deassert cyc/stb, rsp_dat=0, rsp_err=1, rsp_last=1, set remaining=0, go to RSP.
  - Ack and timeout expiry in the same cycle: ack wins.
- RSP:
  - rsp_valid=1; rsp_last = (remaining==0); outputs are held stable until accepted.
  - On rsp_ready with last: go to IDLE; cmd_ready is high the following cycle.
  - On rsp_ready without last: adr += 4 (wraps modulo 2^32), remaining -= 1, clear the timeout counter, go to BUS.
- wbm_ack_i is ignored outside BUS.
- cmd_valid is ignored outside IDLE; the command is not consumed.
- Timing, zero-wait slave and rsp_ready tied high:
  - Command accepted at edge 0 → cyc/stb high in cycle 1.
  - Ack sampled at edge 1 → rsp_valid in cycle 2.
  - Next beat stb in cycle 3, i.e. 2 cycles per beat.
  - cyc deasserts between burst beats (classic cycles only, no pipelining).
- rsp_ready held low stalls RSP indefinitely with no bus activity.

Test Plan:
- Write cmd adr=0x3000_0000, dat=0xDEADBEEF, sel=0xF, ack after 2 wait cycles → one cycle with we=1 and those values; cyc held 3 cycles; single rsp with last=1, err=0, dat=0.
- Read burst adr=0x3000_0010, len=3, slave returns adr^0xA5A5A5A5 with 0 waits → 4 beats at 0x10, 0x14, 0x18, 0x1C; rsp_dat matches each beat; last only on the 4th; cmd_ready low throughout.
- Read burst adr=0xFFFF_FFFC, len=1 → second beat address 0x0000_0000.
- Slave never acks, TIMEOUT=8 → stb high exactly 8 cycles, then rsp err=1, dat=0, last=1; FSM back in IDLE after handshake, with remaining burst beats skipped.
- rsp_ready held low 5 cycles in a burst → rsp outputs stable, no stb; resumes on release. Ack on the timeout-expiry cycle → err=0.
- Assert wb_rst_ni=0 during BUS of beat 2 → cyc/stb/rsp_valid at 0 after that edge. After release, a new read completes normally.
